// File: rtl/iob_nco_period_meter_if.sv
`timescale 1ns/1ps
// iob_nco_period_meter_if: control, measured clock and result signals of the period meter.
interface iob_nco_period_meter_if #(
  parameter int INT_W   = 32,
  parameter int FRAC_W  = 32,
  parameter int AVG_MAX = 8
);
  localparam int AW = $clog2(AVG_MAX + 1);

  logic              cke_i;
  logic              soft_reset_i;
  logic              enable_i;
  logic [AW-1:0]     avg_log2_i;
  logic              meas_clk_i;
  logic [INT_W-1:0]  period_int_o;
  logic [FRAC_W-1:0] period_frac_o;
  logic              valid_o;
  logic              busy_o;
  logic              timeout_o;

  modport master (
    output cke_i, soft_reset_i, enable_i, avg_log2_i, meas_clk_i,
    input  period_int_o, period_frac_o, valid_o, busy_o, timeout_o
  );

  modport slave (
    input  cke_i, soft_reset_i, enable_i, avg_log2_i, meas_clk_i,
    output period_int_o, period_frac_o, valid_o, busy_o, timeout_o
  );
endinterface

// File: rtl/iob_nco_period_meter.sv
`timescale 1ns/1ps
// iob_nco_period_meter: measures the period of meas_clk_i in clk_i cycles as int.frac,
// averaged over 2^avg periods, with back-to-back windows and a no-edge timeout.
module iob_nco_period_meter #(
  parameter int INT_W       = 32,
  parameter int FRAC_W      = 32,
  parameter int AVG_MAX     = 8,
  parameter int TIMEOUT_CYC = 2**20
) (
  input logic                  clk_i,
  input logic                  arst_n_i,
  iob_nco_period_meter_if.slave bus
);
  localparam int AW     = $clog2(AVG_MAX + 1);
  localparam int ACC_W  = INT_W + AVG_MAX;
  localparam int WIDE_W = ACC_W + FRAC_W;
  localparam int NE_W   = AVG_MAX + 1;
  localparam int GAP_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  logic              sync1, sync2, sync3, meas_edge;
  logic [1:0]        state;
  logic [AW-1:0]     avg;
  logic [ACC_W-1:0]  acc;
  logic [NE_W-1:0]   nedge;
  logic [GAP_W-1:0]  gap;
  logic              en_q;
  logic [INT_W-1:0]  period_int;
  logic [FRAC_W-1:0] period_frac;
  logic              valid, timeout;

  logic [AW-1:0]     avg_clamped;
  logic [NE_W-1:0]   nedge_inc, nedge_target;
  logic              closing;
  logic [WIDE_W-1:0] scaled;
  logic [INT_W-1:0]  int_sat;

  // Window arithmetic: clamp the requested averaging, detect the closing edge, scale acc to int.frac.
  always_comb begin
    avg_clamped  = (bus.avg_log2_i > AW'(AVG_MAX)) ? AW'(AVG_MAX) : bus.avg_log2_i;
    nedge_inc    = nedge + NE_W'(1);
    nedge_target = NE_W'(1) << avg;
    closing      = (nedge_inc == nedge_target);
    scaled       = {acc, {FRAC_W{1'b0}}} >> avg;
    int_sat      = (|scaled[WIDE_W-1:FRAC_W+INT_W]) ? {INT_W{1'b1}}
                                                    : scaled[FRAC_W+INT_W-1:FRAC_W];
  end

  // Two-flop synchronizer plus registered rising-edge detect; keeps sampling while cke_i is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      meas_edge <= 1'b0;
    end else if (bus.soft_reset_i) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      meas_edge <= 1'b0;
    end else begin
      sync1     <= bus.meas_clk_i;
      sync2     <= sync1;
      sync3     <= sync2;
      meas_edge <= sync2 & ~sync3;
    end
  end

  // Measurement FSM, window counters, result registers and sticky timeout.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      avg         <= '0;
      acc         <= '0;
      nedge       <= '0;
      gap         <= '0;
      en_q        <= 1'b0;
      period_int  <= '0;
      period_frac <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
    end else if (bus.soft_reset_i) begin
      state       <= IDLE;
      avg         <= '0;
      acc         <= '0;
      nedge       <= '0;
      gap         <= '0;
      en_q        <= 1'b0;
      period_int  <= '0;
      period_frac <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
    end else if (bus.cke_i) begin
      valid <= 1'b0;
      en_q  <= bus.enable_i;
      if (bus.enable_i && !en_q) begin
        timeout <= 1'b0;
      end
      if (!bus.enable_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            avg   <= avg_clamped;
          end
          ARM: begin
            if (meas_edge) begin
              state <= MEAS;
              acc   <= ACC_W'(1);
              nedge <= '0;
              gap   <= GAP_W'(1);
            end
          end
          MEAS: begin
            if (meas_edge) begin
              gap <= GAP_W'(1);
              if (closing) begin
                period_int  <= int_sat;
                period_frac <= scaled[FRAC_W-1:0];
                valid       <= 1'b1;
                acc         <= ACC_W'(1);
                nedge       <= '0;
                avg         <= avg_clamped;
              end else begin
                acc   <= acc + ACC_W'(1);
                nedge <= nedge_inc;
              end
            end else if (gap == GAP_W'(TIMEOUT_CYC - 1)) begin
              timeout <= 1'b1;
              state   <= ARM;
            end else begin
              acc <= acc + ACC_W'(1);
              gap <= gap + GAP_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period_int_o  = period_int;
  assign bus.period_frac_o = period_frac;
  assign bus.valid_o       = valid;
  assign bus.busy_o        = (state != IDLE);
  assign bus.timeout_o     = timeout;
endmodule

// File: tb/tb_iob_nco_period_meter.sv
`timescale 1ns/1ps
// tb_iob_nco_period_meter: table-driven period vectors plus hand-written reset,
// averaging-change, timeout and enable sequences.
module tb_iob_nco_period_meter;
  localparam int INT_W       = 32;
  localparam int FRAC_W      = 32;
  localparam int AVG_MAX     = 8;
  localparam int TIMEOUT_CYC = 64;

  logic clk_i;
  logic arst_n_i;

  iob_nco_period_meter_if #(.INT_W(INT_W), .FRAC_W(FRAC_W), .AVG_MAX(AVG_MAX)) bus ();

  iob_nco_period_meter #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .AVG_MAX(AVG_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk_i),
    .arst_n_i(arst_n_i),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  avg;
    int          p0, p1, p2, p3;
    logic [31:0] exp_int;
    logic [31:0] exp_frac;
    int          exp_gap;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pat[4];
  int   gk;
  bit   gen_on = 0;
  bit   gen_idle = 0;
  bit   idle_level = 0;
  int   rises[$];

  // Free-running system clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Posedge counter used to timestamp meas_clk_i rises and DUT events.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic one_period(input int p);
    if (!bus.meas_clk_i) rises.push_back(cyc);
    bus.meas_clk_i = 1'b1;
    repeat (p / 2) @(posedge clk_i);
    #1;
    bus.meas_clk_i = 1'b0;
    repeat (p - p / 2) @(posedge clk_i);
    #1;
  endtask

  // Measured-clock generator: repeats pat[] while gen_on, otherwise parks at idle_level.
  initial begin
    bus.meas_clk_i = 1'b0;
    gk = 0;
    @(posedge clk_i);
    #1;
    forever begin
      if (gen_on) begin
        gen_idle = 0;
        one_period(pat[gk]);
        gk = (gk + 1) % 4;
      end else begin
        gen_idle = 1;
        gk = 0;
        if (idle_level && !bus.meas_clk_i) rises.push_back(cyc);
        bus.meas_clk_i = idle_level;
        @(posedge clk_i);
        #1;
      end
    end
  end

  function automatic int first_rise_from(input int c);
    foreach (rises[i]) if (rises[i] >= c) return rises[i];
    return -1;
  endfunction

  task automatic wait_valid(input int budget, output bit got, output int n);
    got = 0;
    n = 0;
    while (n < budget && !got) begin
      @(negedge clk_i);
      n++;
      if (bus.valid_o) got = 1;
    end
  endtask

  task automatic stop_gen(input bit level);
    bit ok;
    ok = 0;
    gen_on = 0;
    idle_level = level;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (gen_idle && bus.meas_clk_i == level) begin
        ok = 1;
        break;
      end
    end
    check_output("gen_stop", ok, 1);
  endtask

  task automatic soft_reset_pulse();
    tick();
    bus.soft_reset_i = 1'b1;
    tick();
    bus.soft_reset_i = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    stop_gen(1'b0);
    pat[0] = v.p0; pat[1] = v.p1; pat[2] = v.p2; pat[3] = v.p3;
    tick();
    bus.enable_i   = 1'b0;
    bus.avg_log2_i = v.avg;
    soft_reset_pulse();
    bus.enable_i = 1'b1;
    gen_on = 1;
  endtask

  task automatic wait_timeout(output bit got, output int at);
    got = 0;
    at = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (bus.timeout_o) begin
        got = 1;
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    bit got;
    int n, e, r, last, fire, cnt;

    vecs[0] = '{4'd0, 20, 20, 20, 20, 32'd20, 32'h0000_0000, 20};
    vecs[1] = '{4'd1, 18, 19, 18, 19, 32'h12, 32'h8000_0000, 37};
    vecs[2] = '{4'd2, 18, 18, 18, 19, 32'h12, 32'h4000_0000, 73};
    vecs[3] = '{4'd3, 20, 21, 20, 21, 32'd20, 32'h8000_0000, 164};
    vecs[4] = '{4'd0, 7, 7, 7, 7, 32'd7, 32'h0000_0000, 7};
    vecs[5] = '{4'd3, 5, 5, 5, 6, 32'd5, 32'h4000_0000, 42};
    vecs[6] = '{4'd2, 10, 10, 10, 13, 32'd10, 32'hC000_0000, 43};
    vecs[7] = '{4'd9, 18, 19, 18, 19, 32'h12, 32'h8000_0000, 4736};

    arst_n_i         = 1'b0;
    bus.cke_i        = 1'b1;
    bus.soft_reset_i = 1'b0;
    bus.enable_i     = 1'b0;
    bus.avg_log2_i   = '0;
    repeat (3) tick();
    @(negedge clk_i);
    check_output("reset_valid", bus.valid_o, 0);
    check_output("reset_busy", bus.busy_o, 0);
    check_output("reset_timeout", bus.timeout_o, 0);
    check_output("reset_int", bus.period_int_o, 0);
    check_output("reset_frac", bus.period_frac_o, 0);
    tick();
    arst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      for (int j = 0; j < 3; j++) begin
        wait_valid((j == 0) ? 2 * vecs[i].exp_gap + 100 : vecs[i].exp_gap + 50, got, n);
        check_output($sformatf("vec%0d_valid%0d_seen", i, j), got, 1);
        if (got) begin
          check_output($sformatf("vec%0d_int%0d", i, j), bus.period_int_o, vecs[i].exp_int);
          check_output($sformatf("vec%0d_frac%0d", i, j), bus.period_frac_o, vecs[i].exp_frac);
          if (j > 0) check_output($sformatf("vec%0d_spacing%0d", i, j), n, vecs[i].exp_gap);
        end
      end
    end

    // Asynchronous reset in the middle of a window.
    apply_stimulus(vecs[0]);
    wait_valid(140, got, n);
    check_output("areset_pre_valid", got, 1);
    repeat (5) tick();
    #2;
    arst_n_i = 1'b0;
    #1;
    check_output("areset_busy", bus.busy_o, 0);
    check_output("areset_int", bus.period_int_o, 0);
    check_output("areset_valid", bus.valid_o, 0);
    bus.enable_i = 1'b0;
    tick();
    tick();
    arst_n_i = 1'b1;
    cnt = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (bus.valid_o) cnt++;
    end
    check_output("areset_no_valid_disabled", cnt, 0);
    check_output("areset_idle_busy", bus.busy_o, 0);
    tick();
    e = cyc;
    bus.enable_i = 1'b1;
    wait_valid(80, got, n);
    check_output("areset_first_valid_seen", got, 1);
    r = first_rise_from(e - 2);
    check_output("areset_first_valid_time", cyc, r + 24);
    check_output("areset_first_int", bus.period_int_o, 20);

    // avg_log2_i changed mid-window: current window keeps avg=2, the next one is a single period.
    apply_stimulus(vecs[2]);
    wait_valid(250, got, n);
    check_output("avgchg_first_seen", got, 1);
    check_output("avgchg_first_frac", bus.period_frac_o, 32'h4000_0000);
    repeat (3) tick();
    bus.avg_log2_i = 4'd0;
    wait_valid(130, got, n);
    check_output("avgchg_old_seen", got, 1);
    check_output("avgchg_old_int", bus.period_int_o, 32'h12);
    check_output("avgchg_old_frac", bus.period_frac_o, 32'h4000_0000);
    wait_valid(60, got, n);
    check_output("avgchg_new_seen", got, 1);
    check_output("avgchg_new_int_vs_spacing", bus.period_int_o, n);
    check_output("avgchg_new_int_range", (bus.period_int_o == 18) || (bus.period_int_o == 19), 1);
    check_output("avgchg_new_frac", bus.period_frac_o, 0);

    // Timeout: meas_clk_i stuck high, then resumes, then soft reset clears the flag.
    apply_stimulus(vecs[0]);
    wait_valid(140, got, n);
    wait_valid(70, got, n);
    check_output("to_pre_valid", got, 1);
    stop_gen(1'b1);
    last = rises[$];
    wait_timeout(got, fire);
    check_output("to_seen", got, 1);
    check_output("to_time", fire, last + 67);
    check_output("to_hold_int", bus.period_int_o, 20);
    check_output("to_hold_frac", bus.period_frac_o, 0);
    check_output("to_busy_arm", bus.busy_o, 1);
    tick();
    gen_on = 1;
    for (int j = 0; j < 2; j++) begin
      wait_valid(100, got, n);
      check_output($sformatf("to_resume_seen%0d", j), got, 1);
      check_output($sformatf("to_resume_int%0d", j), bus.period_int_o, 20);
      check_output($sformatf("to_resume_sticky%0d", j), bus.timeout_o, 1);
    end
    soft_reset_pulse();
    @(negedge clk_i);
    check_output("to_softreset_clear", bus.timeout_o, 0);
    check_output("to_softreset_int", bus.period_int_o, 0);

    // Enable dropped mid-window with timeout set, then re-enabled.
    wait_valid(140, got, n);
    wait_valid(70, got, n);
    stop_gen(1'b1);
    wait_timeout(got, fire);
    check_output("en_to_seen", got, 1);
    tick();
    gen_on = 1;
    wait_valid(100, got, n);
    check_output("en_pre_valid", got, 1);
    repeat (7) tick();
    bus.enable_i = 1'b0;
    tick();
    @(negedge clk_i);
    check_output("en_off_busy", bus.busy_o, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.valid_o) cnt++;
    end
    check_output("en_off_no_valid", cnt, 0);
    check_output("en_off_timeout_sticky", bus.timeout_o, 1);
    tick();
    e = cyc;
    bus.enable_i = 1'b1;
    tick();
    @(negedge clk_i);
    check_output("en_on_timeout_clear", bus.timeout_o, 0);
    wait_valid(80, got, n);
    check_output("en_on_valid_seen", got, 1);
    r = first_rise_from(e - 2);
    check_output("en_on_valid_time", cyc, r + 24);
    check_output("en_on_int", bus.period_int_o, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
